// File: rtl/btn_rate_ticker_if.sv
// Button / rate-ticker signal bundle.
//   btn          raw pushbutton level (driven by the board side)
//   btn_pressed  one-cycle pulse per accepted press
//   rate_sel     current rate index 0..3
//   tick         one-cycle pulse at the selected rate
//   sq           square wave toggling on every tick
// master: the side that owns the button and consumes the timing outputs.
// slave:  the ticker itself.
interface btn_rate_ticker_if;
  logic       btn;
  logic       btn_pressed;
  logic [1:0] rate_sel;
  logic       tick;
  logic       sq;

  modport master (
    output btn,
    input  btn_pressed,
    input  rate_sel,
    input  tick,
    input  sq
  );

  modport slave (
    input  btn,
    output btn_pressed,
    output rate_sel,
    output tick,
    output sq
  );
endinterface

// File: rtl/btn_rate_ticker.sv
// Debounced pushbutton rate selector and tick generator for the LED stage.
// A raw button is synchronised and debounced; each clean press steps a 2-bit
// rate index. A divider produces a one-cycle tick every BASE_DIV >> rate_sel
// cycles and a square wave that toggles on every tick.
// Ports:
//   clk  system clock, all state on the rising edge
//   rst  asynchronous active-high reset
//   bus  slave side of btn_rate_ticker_if (btn in; btn_pressed, rate_sel,
//        tick, sq out, all registered)
module btn_rate_ticker #(
  parameter int BASE_DIV        = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  btn_rate_ticker_if.slave   bus
);

  localparam int CNT_W  = $clog2(BASE_DIV);
  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DCNT_W-1:0] DCNT_TOP = DCNT_W'(DEBOUNCE_CYCLES - 1);

  // Divider terminal value for a given rate index; BASE_DIV being a multiple
  // of 8 keeps every shifted period an exact integer.
  function automatic logic [CNT_W-1:0] terminal_count(input logic [1:0] sel);
    return CNT_W'((BASE_DIV >> sel) - 1);
  endfunction

  logic              s1, s2;
  logic              db, db_d;
  logic [DCNT_W-1:0] dcnt;
  logic [CNT_W-1:0]  cnt;
  logic              btn_pressed;
  logic [1:0]        rate_sel;
  logic              tick;
  logic              sq;

  logic              press;
  logic [CNT_W-1:0]  term;

  assign press = db & ~db_d;
  assign term  = terminal_count(rate_sel);

  // Stage: two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bus.btn;
      s2 <= s1;
    end
  end

  // Stage: debouncer; any return to the current level restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db   <= 1'b0;
      dcnt <= '0;
    end else if (s2 == db) begin
      dcnt <= '0;
    end else if (dcnt == DCNT_TOP) begin
      db   <= s2;
      dcnt <= '0;
    end else begin
      dcnt <= dcnt + 1'b1;
    end
  end

  // Stage: rising-edge detect on the debounced level, rate step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_d        <= 1'b0;
      btn_pressed <= 1'b0;
      rate_sel    <= 2'd0;
    end else begin
      db_d        <= db;
      btn_pressed <= press;
      if (press) begin
        rate_sel <= rate_sel + 2'd1;
      end
    end
  end

  // Stage: divider; a rate change restarts the period and suppresses any
  // tick that would have coincided with it, leaving sq untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
      sq   <= 1'b0;
    end else if (press) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == term) begin
      cnt  <= '0;
      tick <= 1'b1;
      sq   <= ~sq;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

  assign bus.btn_pressed = btn_pressed;
  assign bus.rate_sel    = rate_sel;
  assign bus.tick        = tick;
  assign bus.sq          = sq;

endmodule
